// File: rtl/hft_pkg.sv
// Shared types and constants for the market-data analytics blocks.
package hft_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PRIMING = 2'd1,
    ST_STEADY  = 2'd2
  } vol_state_e;

  localparam int RET_WIDTH_DEF = 16;

  // Signed saturation limits of a w-bit return.
  function automatic longint ret_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint ret_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/volatility_estimator_if.sv
// Price-in / volatility-out bus between the feed handler and the spread stage.
interface volatility_estimator_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic [DATA_WIDTH-1:0] i_price;
  logic                  i_price_valid;
  logic                  i_flush;
  logic [DATA_WIDTH-1:0] o_volatility;
  logic                  o_data_valid;

  modport master (
    output i_price,
    output i_price_valid,
    output i_flush,
    input  o_volatility,
    input  o_data_valid
  );

  modport slave (
    input  i_price,
    input  i_price_valid,
    input  i_flush,
    output o_volatility,
    output o_data_valid
  );

endinterface

// File: rtl/return_window.sv
// N-entry circular buffer of returns with running sum and sum of squares;
// each push adds the new return and, once full, retires the oldest one.
module return_window
  import hft_pkg::*;
#(
  parameter int RET_WIDTH   = RET_WIDTH_DEF,
  parameter int WINDOW_LOG2 = 4
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_push,
  input  logic                                   i_flush,
  input  logic signed [RET_WIDTH-1:0]            i_ret,
  output logic signed [RET_WIDTH+WINDOW_LOG2-1:0] o_sum,
  output logic [2*RET_WIDTH+WINDOW_LOG2-1:0]     o_sq,
  output logic                                   o_full
);

  localparam int N     = 1 << WINDOW_LOG2;
  localparam int CW    = WINDOW_LOG2 + 1;
  localparam int PW    = 2 * RET_WIDTH;
  localparam int SUM_W = RET_WIDTH + WINDOW_LOG2;
  localparam int SQ_W  = 2 * RET_WIDTH + WINDOW_LOG2;

  logic signed [RET_WIDTH-1:0] buf_q [N];
  logic [WINDOW_LOG2-1:0]      wptr_q;
  logic [CW-1:0]               count_q;
  logic signed [SUM_W-1:0]     sum_q, sum_d;
  logic [SQ_W-1:0]             sq_q, sq_d;
  logic                        full_s;
  logic signed [RET_WIDTH-1:0] evict_s;
  logic signed [PW-1:0]        ret_ext_s, evict_ext_s;

  always_comb begin
    full_s      = (count_q == CW'(N));
    evict_s     = full_s ? buf_q[wptr_q] : '0;
    ret_ext_s   = PW'(i_ret);
    evict_ext_s = PW'(evict_s);
    sum_d       = sum_q + SUM_W'(i_ret) - SUM_W'(evict_s);
    sq_d        = sq_q + SQ_W'($unsigned(ret_ext_s * ret_ext_s))
                       - SQ_W'($unsigned(evict_ext_s * evict_ext_s));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q  <= '0;
      count_q <= '0;
      sum_q   <= '0;
      sq_q    <= '0;
    end else if (i_flush) begin
      wptr_q  <= '0;
      count_q <= '0;
      sum_q   <= '0;
      sq_q    <= '0;
    end else if (i_push) begin
      wptr_q <= wptr_q + WINDOW_LOG2'(1);
      if (!full_s) begin
        count_q <= count_q + CW'(1);
      end
      sum_q <= sum_d;
      sq_q  <= sq_d;
    end
  end

  // Stale entries are harmless: they are only read back once count says full.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) begin
      buf_q[wptr_q] <= i_ret;
    end
  end

  assign o_sum  = sum_q;
  assign o_sq   = sq_q;
  assign o_full = full_s;

endmodule

// File: rtl/volatility_estimator.sv
// Windowed variance of tick-to-tick price returns, two-cycle pipeline.
// Stage 1 saturates the return and updates the window; stage 2 registers V.
module volatility_estimator
  import hft_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int WINDOW_LOG2 = 4,
  parameter int RET_WIDTH   = RET_WIDTH_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  volatility_estimator_if.slave  bus
);

  localparam int DIFF_W = DATA_WIDTH + 1;
  localparam int SUM_W  = RET_WIDTH + WINDOW_LOG2;
  localparam int SQ_W   = 2 * RET_WIDTH + WINDOW_LOG2;
  localparam int VW     = 2 * SUM_W + 1;
  localparam int EW     = (VW > DATA_WIDTH) ? VW : DATA_WIDTH + 1;
  localparam logic signed [DIFF_W-1:0] RMAX = DIFF_W'(ret_max(RET_WIDTH));
  localparam logic signed [DIFF_W-1:0] RMIN = DIFF_W'(ret_min(RET_WIDTH));

  vol_state_e                 state_q;
  logic [DATA_WIDTH-1:0]      prev_q;
  logic                       s1_valid_q;
  logic [DATA_WIDTH-1:0]      vol_q;
  logic                       dv_q;

  logic                       accept_s, push_s;
  logic signed [DIFF_W-1:0]   diff_s;
  logic signed [RET_WIDTH-1:0] ret_s;
  logic signed [SUM_W-1:0]    sum_s;
  logic [SQ_W-1:0]            sq_s;
  logic                       win_full_s;
  logic signed [VW-1:0]       sum_ext_s, nq_s, ss_s, var_full_s;
  logic [EW-1:0]              var_shift_s;
  logic [DATA_WIDTH-1:0]      var_s;

  always_comb begin
    accept_s = bus.i_price_valid && !bus.i_flush;
    push_s   = accept_s && (state_q != ST_EMPTY);
    diff_s   = $signed({1'b0, bus.i_price}) - $signed({1'b0, prev_q});
    if (diff_s > RMAX) begin
      ret_s = RET_WIDTH'(RMAX);
    end else if (diff_s < RMIN) begin
      ret_s = RET_WIDTH'(RMIN);
    end else begin
      ret_s = RET_WIDTH'(diff_s);
    end
  end

  // N*Q >= S*S mathematically; the sign test only guards against misuse.
  always_comb begin
    sum_ext_s  = VW'(sum_s);
    nq_s       = $signed(VW'(sq_s)) <<< WINDOW_LOG2;
    ss_s       = sum_ext_s * sum_ext_s;
    var_full_s = nq_s - ss_s;
    if (var_full_s[VW-1]) begin
      var_shift_s = '0;
    end else begin
      var_shift_s = EW'($unsigned(var_full_s) >> (2 * WINDOW_LOG2));
    end
    if (|var_shift_s[EW-1:DATA_WIDTH]) begin
      var_s = '1;
    end else begin
      var_s = var_shift_s[DATA_WIDTH-1:0];
    end
  end

  return_window #(
    .RET_WIDTH   (RET_WIDTH),
    .WINDOW_LOG2 (WINDOW_LOG2)
  ) u_window (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push_s),
    .i_flush (bus.i_flush),
    .i_ret   (ret_s),
    .o_sum   (sum_s),
    .o_sq    (sq_s),
    .o_full  (win_full_s)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_EMPTY;
      prev_q     <= '0;
      s1_valid_q <= 1'b0;
      vol_q      <= '0;
      dv_q       <= 1'b0;
    end else if (bus.i_flush) begin
      state_q    <= ST_EMPTY;
      s1_valid_q <= 1'b0;
      vol_q      <= '0;
      dv_q       <= 1'b0;
    end else begin
      s1_valid_q <= push_s;
      dv_q       <= s1_valid_q && win_full_s;
      vol_q      <= (s1_valid_q && win_full_s) ? var_s : '0;
      if (accept_s) begin
        prev_q <= bus.i_price;
      end
      case (state_q)
        ST_EMPTY:   if (accept_s) state_q <= ST_PRIMING;
        ST_PRIMING: if (win_full_s) state_q <= ST_STEADY;
        ST_STEADY:  state_q <= ST_STEADY;
        default:    state_q <= ST_EMPTY;
      endcase
    end
  end

  assign bus.o_volatility = vol_q;
  assign bus.o_data_valid = dv_q;

endmodule

// File: tb/tb_volatility_estimator.sv
// Directed bench for volatility_estimator with a queue-based scoreboard.
module tb_volatility_estimator;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] exp_q [$];

  volatility_estimator_if #(.DATA_WIDTH(32)) bus ();

  volatility_estimator #(
    .DATA_WIDTH  (32),
    .WINDOW_LOG2 (4),
    .RET_WIDTH   (16)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per valid output, idle cycles must read zero.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.o_data_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid: got valid with volatility %0d, expected no output",
                   bus.o_volatility);
        end else begin
          check("volatility", bus.o_volatility, exp_q.pop_front());
        end
      end else begin
        check("idle_zero", bus.o_volatility, 32'd0);
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] p, input logic f,
                      input logic expect_out, input logic [31:0] ev);
    if (expect_out) exp_q.push_back(ev);
    bus.i_price_valid = v;
    bus.i_price       = p;
    bus.i_flush       = f;
    @(posedge clk);
    #1;
    bus.i_price_valid = 1'b0;
    bus.i_flush       = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  function automatic logic [31:0] alt(input int i);
    return (i % 2 == 1) ? 32'd1000 : 32'd1002;
  endfunction

  initial begin
    rst = 1'b1;
    bus.i_price_valid = 1'b0;
    bus.i_price = 32'd0;
    bus.i_flush = 1'b0;
    #1;
    check("reset_valid", {31'd0, bus.o_data_valid}, 32'd0);
    check("reset_vol", bus.o_volatility, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Constant price: first output on sample 17, zero variance
    for (int i = 1; i <= 17; i++) step(1'b1, 32'd1000, 1'b0, i == 17, 32'd0);
    idle(3);
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);

    // Alternating price, back-to-back: V=4 on every full-window sample
    for (int i = 1; i <= 20; i++) step(1'b1, alt(i), 1'b0, i >= 17, 32'd4);
    idle(3);
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);

    // Ramp with an invalid cycle inside the window (junk price ignored)
    for (int i = 0; i <= 16; i++) begin
      step(1'b1, 32'd1000 + 32'(i), 1'b0, i == 16, 32'd0);
      if (i == 8) step(1'b0, 32'd77777, 1'b0, 1'b0, 32'd0);
    end
    idle(3);
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);

    // Positive then negative return saturation
    step(1'b1, 32'd1000, 1'b0, 1'b0, 32'd0);
    for (int i = 2; i <= 17; i++) step(1'b1, 32'd101000, 1'b0, i == 17, 32'd62910720);
    step(1'b1, 32'd101000, 1'b0, 1'b1, 32'd0);
    step(1'b1, 32'd1000, 1'b0, 1'b1, 32'd62914560);
    idle(3);
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);

    // Flush together with a sample on sample 10; the sample is discarded
    for (int i = 1; i <= 9; i++) step(1'b1, alt(i), 1'b0, 1'b0, 32'd0);
    step(1'b1, alt(10), 1'b1, 1'b0, 32'd0);
    for (int j = 1; j <= 17; j++) step(1'b1, alt(j), 1'b0, j == 17, 32'd4);
    // Flush right behind sample 18 kills its in-flight stage-2 result
    step(1'b1, alt(18), 1'b0, 1'b0, 32'd0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    idle(3);

    // Reset between edges while a valid result is being presented
    for (int i = 1; i <= 17; i++) step(1'b1, alt(i), 1'b0, i == 17, 32'd4);
    step(1'b1, alt(18), 1'b0, 1'b0, 32'd0);
    #5;
    check("pre_reset_valid", {31'd0, bus.o_data_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, bus.o_data_valid}, 32'd0);
    check("async_rst_vol", bus.o_volatility, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 1; i <= 17; i++) step(1'b1, alt(i), 1'b0, i == 17, 32'd4);
    idle(4);

    check("drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/volatility_estimator.md
VOLATILITY_ESTIMATOR -- requirements
Module: volatility_estimator

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the width of the price input and the volatility output.
REQ-002 Parameter WINDOW_LOG2, default 4, gives a window of N = 2^WINDOW_LOG2 returns.
REQ-003 Parameter RET_WIDTH, default 16, sets the width of the saturated signed return.
REQ-004 Port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port i_price, input, DATA_WIDTH bits: unsigned mid-price in ticks.
REQ-007 Port i_price_valid, input, 1 bit: i_price is accepted on this edge.
REQ-008 Port i_flush, input, 1 bit: discard all history (session restart).
REQ-009 Port o_volatility, output, DATA_WIDTH bits: windowed return variance, unsigned, feeds the spread stage i_volatility.
REQ-010 Port o_data_valid, output, 1 bit: o_volatility is valid; feeds the spread stage i_data_valid.

Function
REQ-011 The block SHALL run the FSM states EMPTY (no previous price), PRIMING (fewer than N returns) and STEADY (window full).
- EMPTY to PRIMING: on an accepted sample; only the previous price is stored, no return is produced.
- PRIMING to STEADY: when the return count reaches N.
- Any state to EMPTY: on i_flush.
REQ-012 Each accepted sample in PRIMING or STEADY SHALL form return r = i_price - prev_price.
- r is computed at DATA_WIDTH+1 bits, signed.
- r saturates to the RET_WIDTH signed range [-32768, 32767] at the default width.
- prev_price is then updated to i_price.
REQ-013 Returns SHALL be held in an N-entry circular buffer with a wrapping write pointer.
- Running sum S is RET_WIDTH+WINDOW_LOG2 bits, signed.
- Running sum of squares Q is 2*RET_WIDTH+WINDOW_LOG2 bits, unsigned.
- Per accepted sample: add the new return; in STEADY also subtract the evicted return, all in the same cycle.
REQ-014 The block SHALL compute variance V = (N*Q - S*S) >> (2*WINDOW_LOG2).
- Truncate toward zero.
- Saturate to 2^DATA_WIDTH - 1.
REQ-015 Latency SHALL be 2 cycles: a sample accepted at edge k produces o_data_valid=1 with o_volatility=V in the cycle after edge k+1.
- Stage 1 (edge k) updates the buffer and sums.
- Stage 2 (edge k+1) registers V.
REQ-016 o_data_valid SHALL pulse for exactly one cycle per accepted sample whose stage-1 update leaves the window full.
- The first pulse comes from the (N+1)th price after reset or flush.
REQ-017 o_volatility SHALL be 0 in every cycle where o_data_valid is 0.
REQ-018 Back-to-back samples on every cycle SHALL be sustained with no bubbles and no backpressure.
REQ-019 When i_flush and i_price_valid are high on the same edge, flush SHALL win and the sample SHALL be discarded.
REQ-020 On i_flush the block SHALL:
- clear S, Q, the count and the pointer on that edge;
- drive o_data_valid low from the next cycle;
- suppress any stage-2 result still in flight.
REQ-021 i_price_valid=0 SHALL leave all state unchanged.

Reset
REQ-022 Asserting i_rst SHALL immediately, with no clock edge, set:
- FSM to EMPTY;
- S, Q, count and pointer to 0;
- o_volatility and o_data_valid to 0;
- pipeline valid to 0.
Buffer contents need not be cleared.
REQ-023 After i_rst deasserts, the first accepted sample SHALL be treated as the first price of a new window.

Structure
REQ-024 The shared package hft_pkg SHALL hold the FSM state enum, the RET_WIDTH default and the return-saturation limits.
REQ-025 The circular buffer, S and Q SHALL live in one sub-module, return_window.
- Inputs: push, flush, return.
- Outputs: S, Q, full.
REQ-026 volatility_estimator SHALL hold the FSM, the return/saturation logic and the variance stage.

Verification (N=16)
REQ-027 Constant price: 17 samples of 1000 -> first o_data_valid on sample 17, o_volatility=0.
REQ-028 Alternating price: 1000,1002,... for 17+ samples -> S=0, Q=64, o_volatility=4 on every valid output.
REQ-029 Ramp price: 1000,1001,...,1016 -> S=16, Q=16, o_volatility=0.
REQ-030 Saturation: 1000, then 1000+100000, then 15 samples of 1000+100000.
- The first return clips to 32767; the window holds 32767 plus 15 zeros.
- Required output o_volatility=62910720.
REQ-031 Flush: alternating stream with i_flush raised together with i_price_valid on sample 10.
- No valid outputs after the flush until 17 further samples.
- Then o_volatility=4.
REQ-032 Reset mid-stream: i_rst asserted between clock edges in STEADY.
- o_data_valid and o_volatility go to 0 without a clock edge.
- After release, 17 fresh samples are needed before the next valid output.
